// File: rtl/audiotypes.sv
// Shared types for the audio playout block: playback state encoding and the
// output rate divider encoding with its counter-mask helper.
package audiotypes;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_PLAY = 2'd2
    } play_state_t;

    typedef enum logic [1:0] {
        RATE_DIV1     = 2'd0,
        RATE_DIV2     = 2'd1,
        RATE_DIV4     = 2'd2,
        RATE_DIV4_ALT = 2'd3
    } rate_div_t;

    // Modulo mask applied to the 2-bit divider counter; code 3 aliases /4.
    function automatic logic [1:0] rate_mask(input logic [1:0] rate_div);
        case (rate_div_t'(rate_div))
            RATE_DIV1: rate_mask = 2'd0;
            RATE_DIV2: rate_mask = 2'd1;
            default:   rate_mask = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Single-channel sample FIFO with occupancy count; clr empties it and wins
// over any same-cycle write or read.
module sample_fifo #(
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clr,
    input  logic                        wr,
    input  logic [SAMPLE_W-1:0]         wr_data,
    input  logic                        rd,
    output logic [SAMPLE_W-1:0]         rd_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;

    logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                wr_ok;
    logic                rd_ok;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = wr && !full && !clr;
    assign rd_ok   = rd && !empty && !clr;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(wr_ok) - CW'(rd_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/audio_playout.sv
// Multi-channel audio playout: per-channel FIFOs, prefill/arm sequencing,
// divided output ticks, underflow detection and slew-to-zero when stopped.
//
//   state | meaning
//   IDLE  | waiting for every FIFO to reach PREFILL; outputs slew to zero
//   ARM   | one sample_tick guard interval before playback; still slewing
//   PLAY  | pop all FIFOs on each output tick; empty FIFO -> underflow, IDLE
module audio_playout
    import audiotypes::*;
#(
    parameter int CHANNELS   = 2,
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int PREFILL    = FIFO_DEPTH - 2,
    parameter int SLEW_STEP  = 1
) (
    input  logic                                                clk,
    input  logic                                                reset_n,
    input  logic                                                sample_tick,
    input  logic [1:0]                                          rate_div,
    input  logic                                                mono,
    input  logic signed [SAMPLE_W-1:0]                          in_sample,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0]  in_channel,
    input  logic                                                in_valid,
    output logic                                                in_ready,
    input  logic                                                flush,
    output logic [CHANNELS*SAMPLE_W-1:0]                        out_sample,
    output logic                                                out_strobe,
    output logic                                                playing,
    output logic                                                underflow
);

    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    play_state_t         state, state_nxt;
    logic [CHANNELS-1:0] f_full, f_empty, f_wr, ch_hit;
    logic [CNT_W-1:0]    f_count [CHANNELS];
    logic [SAMPLE_W-1:0] f_data  [CHANNELS];
    logic                mono_eff, prefilled, all_nonempty, tick_out;
    logic                pop, strobe_nxt, uf_nxt, slew_en, slew_tog;
    logic [1:0]          div_cnt, div_mask;
    logic [CHANNELS*SAMPLE_W-1:0] out_nxt;

    function automatic logic [SAMPLE_W-1:0] slew(input logic signed [SAMPLE_W-1:0] v);
        logic signed [SAMPLE_W:0] wide;
        logic signed [SAMPLE_W:0] step;
        wide = (SAMPLE_W+1)'(v);
        step = (SAMPLE_W+1)'(SLEW_STEP);
        if (wide > step)       slew = SAMPLE_W'(wide - step);
        else if (wide < -step) slew = SAMPLE_W'(wide + step);
        else                   slew = '0;
    endfunction

    assign mono_eff     = mono && (CHANNELS > 1);
    assign all_nonempty = ~|f_empty;
    assign tick_out     = sample_tick && (div_cnt == 2'd0);
    assign playing      = (state == ST_PLAY);
    assign slew_en      = (state != ST_PLAY) && slew_tog;

    // Out-of-range channel select is always ready and simply writes nowhere.
    always_comb begin
        ch_hit = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (in_channel == CH_W'(ch)) ch_hit[ch] = 1'b1;
        end
        if (mono_eff)     in_ready = ~|f_full;
        else if (~|ch_hit) in_ready = 1'b1;
        else              in_ready = ~|(f_full & ch_hit);
        f_wr = '0;
        if (in_valid && in_ready && !flush) f_wr = mono_eff ? '1 : ch_hit;
    end

    always_comb begin
        prefilled = 1'b1;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (f_count[ch] < CNT_W'(PREFILL)) prefilled = 1'b0;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_fifo
        sample_fifo #(
            .SAMPLE_W   (SAMPLE_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (flush),
            .wr      (f_wr[g]),
            .wr_data (in_sample),
            .rd      (pop),
            .rd_data (f_data[g]),
            .full    (f_full[g]),
            .empty   (f_empty[g]),
            .count   (f_count[g])
        );
    end

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        strobe_nxt = 1'b0;
        uf_nxt     = 1'b0;
        if (flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (sample_tick && prefilled) state_nxt = ST_ARM;
                ST_ARM:  if (sample_tick) state_nxt = ST_PLAY;
                ST_PLAY: begin
                    if (tick_out) begin
                        if (all_nonempty) begin
                            pop        = 1'b1;
                            strobe_nxt = 1'b1;
                        end else begin
                            uf_nxt    = 1'b1;
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        out_nxt = out_sample;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (pop)
                out_nxt[ch*SAMPLE_W +: SAMPLE_W] = f_data[ch];
            else if (slew_en)
                out_nxt[ch*SAMPLE_W +: SAMPLE_W] = slew(out_sample[ch*SAMPLE_W +: SAMPLE_W]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            out_sample <= '0;
            out_strobe <= 1'b0;
            underflow  <= 1'b0;
            slew_tog   <= 1'b0;
        end else begin
            state      <= state_nxt;
            out_sample <= out_nxt;
            out_strobe <= strobe_nxt;
            underflow  <= uf_nxt;
            slew_tog   <= (state == ST_PLAY) ? 1'b0 : ~slew_tog;
        end
    end

    // A new rate_div is sampled only at an output tick, so the current
    // divided period always completes before the rate changes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt  <= 2'd0;
            div_mask <= 2'd0;
        end else if (state != ST_PLAY) begin
            div_cnt  <= 2'd0;
            div_mask <= rate_mask(rate_div);
        end else if (sample_tick) begin
            if (div_cnt == 2'd0) begin
                div_mask <= rate_mask(rate_div);
                div_cnt  <= 2'd1 & rate_mask(rate_div);
            end else begin
                div_cnt  <= (div_cnt + 2'd1) & div_mask;
            end
        end
    end

endmodule
